// File: rtl/hazard_ctrl.sv
// Pipeline sequencing controller: resolves load-use hazards, shared-RAM structural
// conflicts between fetch and MEM-stage data access, and taken branches resolved in EX.
// Drives per-stage stall/flush, shared-RAM ownership and a saturating stall-cycle counter.
module hazard_ctrl #(
  parameter int unsigned REG_AW     = 4,
  parameter int unsigned MEM_CYCLES = 2,
  parameter int unsigned CNT_W      = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [REG_AW-1:0] id_reg1_addr,
  input  logic              id_reg1_used,
  input  logic [REG_AW-1:0] id_reg2_addr,
  input  logic              id_reg2_used,
  input  logic              ex_wb_en,
  input  logic [REG_AW-1:0] ex_wb_addr,
  input  logic              ex_is_load,
  input  logic              mem_req,
  input  logic              branch_taken,
  input  logic              cnt_clr,
  output logic              pc_stall,
  output logic              ifid_stall,
  output logic              ifid_flush,
  output logic              idex_stall,
  output logic              idex_flush,
  output logic              exmem_stall,
  output logic              memwb_bubble,
  output logic              ram_owner,
  output logic [CNT_W-1:0]  stall_cycles,
  output logic              state_o
);

  // cnt only ever holds MEM_CYCLES-2 down to 0.
  localparam int unsigned CntW = (MEM_CYCLES > 2) ? $clog2(MEM_CYCLES - 1) : 1;
  localparam logic [CntW-1:0] CntLoad = (MEM_CYCLES > 1) ? CntW'(MEM_CYCLES - 2) : '0;
  localparam bit MultiCycle = (MEM_CYCLES > 1);

  typedef enum logic [0:0] {StRun, StMemBusy} state_e;

  state_e            state_q, state_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic [CNT_W-1:0]  stall_cycles_q, stall_cycles_d;

  logic load_use;
  logic acc_last;
  logic acc_hold;

  assign load_use = ex_is_load & ex_wb_en &
                    ((id_reg1_used & (id_reg1_addr == ex_wb_addr)) |
                     (id_reg2_used & (id_reg2_addr == ex_wb_addr)));

  assign acc_last = ((state_q == StRun) & mem_req & !MultiCycle) |
                    ((state_q == StMemBusy) & (cnt_q == '0));
  assign acc_hold = ((state_q == StRun) & mem_req & MultiCycle) |
                    ((state_q == StMemBusy) & (cnt_q != '0));

  // Control outputs: combinational from state, cnt and hazard inputs; all low in reset.
  always_comb begin
    pc_stall     = 1'b0;
    ifid_stall   = 1'b0;
    ifid_flush   = 1'b0;
    idex_stall   = 1'b0;
    idex_flush   = 1'b0;
    exmem_stall  = 1'b0;
    memwb_bubble = 1'b0;
    ram_owner    = 1'b0;
    if (rst) begin
      if (acc_hold) begin
        // Whole front end frozen; the held EX instruction re-presents branch/load-use later.
        ram_owner    = 1'b1;
        pc_stall     = 1'b1;
        ifid_stall   = 1'b1;
        idex_stall   = 1'b1;
        exmem_stall  = 1'b1;
        memwb_bubble = 1'b1;
      end else if (acc_last) begin
        // Fetch slot lost this cycle, so IF/ID gets a bubble unless it must hold.
        ram_owner  = 1'b1;
        pc_stall   = 1'b1;
        ifid_flush = 1'b1;
        if (branch_taken) begin
          pc_stall   = 1'b0;
          idex_flush = 1'b1;
        end else if (load_use) begin
          ifid_stall = 1'b1;
          ifid_flush = 1'b0;
          idex_flush = 1'b1;
        end
      end else if (branch_taken) begin
        ifid_flush = 1'b1;
        idex_flush = 1'b1;
      end else if (load_use) begin
        pc_stall   = 1'b1;
        ifid_stall = 1'b1;
        idex_flush = 1'b1;
      end
    end
  end

  // Access sequencer: RUN -> MEM_BUSY for multi-cycle accesses, count down, return.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      StRun: begin
        if (mem_req && MultiCycle) begin
          state_d = StMemBusy;
          cnt_d   = CntLoad;
        end
      end
      StMemBusy: begin
        if (cnt_q == '0) begin
          state_d = StRun;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      default: begin
        state_d = StRun;
        cnt_d   = '0;
      end
    endcase
  end

  // Stall-cycle counter: clear beats increment, saturates at all-ones.
  always_comb begin
    stall_cycles_d = stall_cycles_q;
    if (cnt_clr) begin
      stall_cycles_d = '0;
    end else if (pc_stall && !(&stall_cycles_q)) begin
      stall_cycles_d = stall_cycles_q + 1'b1;
    end
  end

  // State registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q        <= StRun;
      cnt_q          <= '0;
      stall_cycles_q <= '0;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      stall_cycles_q <= stall_cycles_d;
    end
  end

  assign stall_cycles = stall_cycles_q;
  assign state_o      = (state_q == StMemBusy);

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed testbench for hazard_ctrl: a default instance (MEM_CYCLES=2, 16-bit counter)
// and a small instance (MEM_CYCLES=1, 2-bit counter) for single-cycle access and saturation.
module tb_hazard_ctrl;

  logic       clk;
  logic       rst;
  logic [3:0] id_reg1_addr;
  logic       id_reg1_used;
  logic [3:0] id_reg2_addr;
  logic       id_reg2_used;
  logic       ex_wb_en;
  logic [3:0] ex_wb_addr;
  logic       ex_is_load;
  logic       mem_req;
  logic       branch_taken;
  logic       cnt_clr;

  logic        pc_stall_a, ifid_stall_a, ifid_flush_a, idex_stall_a, idex_flush_a;
  logic        exmem_stall_a, memwb_bubble_a, ram_owner_a, state_a;
  logic [15:0] stall_cycles_a;
  logic        pc_stall_b, ifid_stall_b, ifid_flush_b, idex_stall_b, idex_flush_b;
  logic        exmem_stall_b, memwb_bubble_b, ram_owner_b, state_b;
  logic [1:0]  stall_cycles_b;

  logic [7:0] ctl_a;
  logic [7:0] ctl_b;

  int checks;
  int errors;

  // ctl bit order: pc_stall ifid_stall ifid_flush idex_stall idex_flush exmem_stall
  //                memwb_bubble ram_owner
  localparam logic [7:0] CtlIdle    = 8'b0000_0000;
  localparam logic [7:0] CtlHold    = 8'b1101_0111;
  localparam logic [7:0] CtlLast    = 8'b1010_0001;
  localparam logic [7:0] CtlLastBr  = 8'b0010_1001;
  localparam logic [7:0] CtlLastLu  = 8'b1100_1001;
  localparam logic [7:0] CtlLoadUse = 8'b1100_1000;
  localparam logic [7:0] CtlBranch  = 8'b0010_1000;

  assign ctl_a = {pc_stall_a, ifid_stall_a, ifid_flush_a, idex_stall_a, idex_flush_a,
                  exmem_stall_a, memwb_bubble_a, ram_owner_a};
  assign ctl_b = {pc_stall_b, ifid_stall_b, ifid_flush_b, idex_stall_b, idex_flush_b,
                  exmem_stall_b, memwb_bubble_b, ram_owner_b};

  hazard_ctrl #(.REG_AW(4), .MEM_CYCLES(2), .CNT_W(16)) u_dut_a (
    .clk          (clk),
    .rst          (rst),
    .id_reg1_addr (id_reg1_addr),
    .id_reg1_used (id_reg1_used),
    .id_reg2_addr (id_reg2_addr),
    .id_reg2_used (id_reg2_used),
    .ex_wb_en     (ex_wb_en),
    .ex_wb_addr   (ex_wb_addr),
    .ex_is_load   (ex_is_load),
    .mem_req      (mem_req),
    .branch_taken (branch_taken),
    .cnt_clr      (cnt_clr),
    .pc_stall     (pc_stall_a),
    .ifid_stall   (ifid_stall_a),
    .ifid_flush   (ifid_flush_a),
    .idex_stall   (idex_stall_a),
    .idex_flush   (idex_flush_a),
    .exmem_stall  (exmem_stall_a),
    .memwb_bubble (memwb_bubble_a),
    .ram_owner    (ram_owner_a),
    .stall_cycles (stall_cycles_a),
    .state_o      (state_a)
  );

  hazard_ctrl #(.REG_AW(4), .MEM_CYCLES(1), .CNT_W(2)) u_dut_b (
    .clk          (clk),
    .rst          (rst),
    .id_reg1_addr (id_reg1_addr),
    .id_reg1_used (id_reg1_used),
    .id_reg2_addr (id_reg2_addr),
    .id_reg2_used (id_reg2_used),
    .ex_wb_en     (ex_wb_en),
    .ex_wb_addr   (ex_wb_addr),
    .ex_is_load   (ex_is_load),
    .mem_req      (mem_req),
    .branch_taken (branch_taken),
    .cnt_clr      (cnt_clr),
    .pc_stall     (pc_stall_b),
    .ifid_stall   (ifid_stall_b),
    .ifid_flush   (ifid_flush_b),
    .idex_stall   (idex_stall_b),
    .idex_flush   (idex_flush_b),
    .exmem_stall  (exmem_stall_b),
    .memwb_bubble (memwb_bubble_b),
    .ram_owner    (ram_owner_b),
    .stall_cycles (stall_cycles_b),
    .state_o      (state_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Advance one rising edge, then settle away from it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    id_reg1_addr = 4'd0;
    id_reg1_used = 1'b0;
    id_reg2_addr = 4'd0;
    id_reg2_used = 1'b0;
    ex_wb_en     = 1'b0;
    ex_wb_addr   = 4'd0;
    ex_is_load   = 1'b0;
    mem_req      = 1'b0;
    branch_taken = 1'b0;
    cnt_clr      = 1'b0;
  endtask

  task automatic set_load_use(input logic [3:0] dst, input logic [3:0] src2);
    ex_is_load   = 1'b1;
    ex_wb_en     = 1'b1;
    ex_wb_addr   = dst;
    id_reg2_used = 1'b1;
    id_reg2_addr = src2;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    clear_inputs();
    rst = 1'b0;

    // Reset dominates hazard inputs.
    mem_req      = 1'b1;
    branch_taken = 1'b1;
    set_load_use(4'd3, 4'd3);
    #2;
    check_eq("rst_ctl", ctl_a, CtlIdle);
    check_eq("rst_state", state_a, 0);
    check_eq("rst_cnt", stall_cycles_a, 0);
    check_eq("rst_ctl_b", ctl_b, CtlIdle);
    tick();
    check_eq("rst_ctl_edge", ctl_a, CtlIdle);
    check_eq("rst_state_edge", state_a, 0);

    // Release with mem_req and branch still high: HOLD, then LAST with branch.
    set_load_use(4'd3, 4'd4);
    rst = 1'b1;
    #1;
    check_eq("rel_hold", ctl_a, CtlHold);
    check_eq("rel_state_pre", state_a, 0);
    tick();
    check_eq("rel_state_busy", state_a, 1);
    check_eq("rel_last_branch", ctl_a, CtlLastBr);
    check_eq("rel_cnt1", stall_cycles_a, 1);
    tick();
    check_eq("rel_state_run", state_a, 0);
    check_eq("rel_cnt_hold", stall_cycles_a, 1);

    // Quiet cycle with clear.
    clear_inputs();
    cnt_clr = 1'b1;
    #1;
    check_eq("idle_ctl", ctl_a, CtlIdle);
    tick();
    check_eq("clr_cnt", stall_cycles_a, 0);
    cnt_clr = 1'b0;

    // Load-use on operand 2 in RUN.
    set_load_use(4'd3, 4'd3);
    #1;
    check_eq("lu_op2", ctl_a, CtlLoadUse);
    tick();
    check_eq("lu_cnt", stall_cycles_a, 1);
    id_reg2_addr = 4'd4;
    #1;
    check_eq("lu_addr_miss", ctl_a, CtlIdle);
    id_reg2_used = 1'b0;
    id_reg1_used = 1'b1;
    id_reg1_addr = 4'd3;
    #1;
    check_eq("lu_op1", ctl_a, CtlLoadUse);
    ex_wb_en = 1'b0;
    #1;
    check_eq("lu_no_wb", ctl_a, CtlIdle);
    ex_wb_en   = 1'b1;
    ex_is_load = 1'b0;
    #1;
    check_eq("lu_not_load", ctl_a, CtlIdle);
    ex_is_load   = 1'b1;
    branch_taken = 1'b1;
    #1;
    check_eq("br_over_lu", ctl_a, CtlBranch);

    // Structural conflict, single mem_req pulse.
    clear_inputs();
    cnt_clr = 1'b1;
    tick();
    cnt_clr = 1'b0;
    mem_req = 1'b1;
    #1;
    check_eq("st_c0", ctl_a, CtlHold);
    tick();
    mem_req = 1'b0;
    #1;
    check_eq("st_c1", ctl_a, CtlLast);
    tick();
    check_eq("st_c2", ctl_a, CtlIdle);
    check_eq("st_cnt", stall_cycles_a, 2);

    // Back-to-back access; load-use on the last cycle of the first one.
    mem_req = 1'b1;
    #1;
    check_eq("bb_c0", ctl_a, CtlHold);
    tick();
    set_load_use(4'd5, 4'd5);
    #1;
    check_eq("last_lu", ctl_a, CtlLastLu);
    tick();
    check_eq("bb_state_run", state_a, 0);
    check_eq("bb_c2_hold", ctl_a, CtlHold);
    tick();
    check_eq("bb_state_busy", state_a, 1);

    // Reset mid-access aborts it.
    rst = 1'b0;
    #1;
    check_eq("abort_ctl", ctl_a, CtlIdle);
    check_eq("abort_state", state_a, 0);
    check_eq("abort_cnt", stall_cycles_a, 0);
    clear_inputs();
    rst = 1'b1;
    #1;
    check_eq("abort_rel", ctl_a, CtlIdle);

    // Clear wins over a concurrent stall.
    set_load_use(4'd2, 4'd2);
    tick();
    check_eq("pre_clr_cnt", stall_cycles_a, 1);
    cnt_clr = 1'b1;
    #1;
    check_eq("clr_with_stall_ctl", ctl_a, CtlLoadUse);
    tick();
    check_eq("clr_beats_inc", stall_cycles_a, 0);

    // Single-cycle access instance: LAST immediately, never leaves RUN, counter saturates.
    clear_inputs();
    cnt_clr = 1'b1;
    tick();
    cnt_clr = 1'b0;
    check_eq("b_cnt_clr", stall_cycles_b, 0);
    mem_req = 1'b1;
    #1;
    check_eq("b_last", ctl_b, CtlLast);
    for (int i = 0; i < 4; i++) tick();
    check_eq("b_state_run", state_b, 0);
    check_eq("b_saturate", stall_cycles_b, 3);
    tick();
    check_eq("b_sat_hold", stall_cycles_b, 3);
    branch_taken = 1'b1;
    #1;
    check_eq("b_last_branch", ctl_b, CtlLastBr);
    branch_taken = 1'b0;
    cnt_clr = 1'b1;
    tick();
    check_eq("b_clr_sat", stall_cycles_b, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
